// File: rtl/rs_derivative_writer.sv
// Streams the formal derivative of the error-locator polynomial into a ping-ponged
// derivative RAM (bank = address bit 7) and announces finished banks to the Forney stage.
module rs_derivative_writer #(
  parameter int unsigned MAX_DEG = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       lambda_valid,
  input  logic [7:0] lambda_coef,
  input  logic       lambda_last,
  output logic       lambda_ready,
  output logic [7:0] buf_data,
  output logic [7:0] buf_wraddress,
  output logic       buf_wren,
  output logic       deriv_done,
  output logic       deriv_bank,
  output logic [6:0] deriv_degree,
  output logic       deriv_zero,
  output logic       deriv_overflow,
  input  logic       bank_release,
  input  logic       release_bank
);

  localparam logic [7:0] MaxDeg   = 8'(MAX_DEG);
  localparam logic [7:0] LastSlot = 8'(MAX_DEG - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StFlush, StDone} state_e;

  state_e     state_q, state_d;
  logic       run_q;
  logic       wr_bank_q, wr_bank_d;
  logic [1:0] busy_q, busy_d;
  logic [7:0] k_q, k_d;
  logic [7:0] ptr_q, ptr_d;
  logic [6:0] deg_q, deg_d;
  logic       nz_q, nz_d;
  logic       ovf_q, ovf_d;

  logic       wren_q, wren_d;
  logic [7:0] data_q, data_d;
  logic [7:0] addr_q, addr_d;
  logic       done_q, done_d;
  logic       dbank_q, dbank_d;
  logic [6:0] ddeg_q, ddeg_d;
  logic       dzero_q, dzero_d;
  logic       dovf_q, dovf_d;

  logic       beat;
  logic [7:0] beat_k;
  logic [6:0] slot;

  // run_q keeps ready low while reset is asserted and for the first cycle after it.
  assign lambda_ready = run_q && !busy_q[wr_bank_q] &&
                        ((state_q == StIdle) || (state_q == StLoad) || (state_q == StDrain));
  assign beat = lambda_valid && lambda_ready;

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    busy_d    = busy_q;
    k_d       = k_q;
    ptr_d     = ptr_q;
    deg_d     = deg_q;
    nz_d      = nz_q;
    ovf_d     = ovf_q;
    wren_d    = 1'b0;
    data_d    = data_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    dbank_d   = dbank_q;
    ddeg_d    = ddeg_q;
    dzero_d   = dzero_q;
    dovf_d    = dovf_q;

    beat_k = (state_q == StIdle) ? 8'd0 : k_q;
    slot   = 7'(beat_k - 8'd1);

    if (bank_release) begin
      busy_d[release_bank] = 1'b0;
    end

    unique case (state_q)
      StIdle, StLoad: begin
        if (beat) begin
          if (state_q == StIdle) begin
            deg_d = '0;
            nz_d  = 1'b0;
            ovf_d = 1'b0;
          end
          k_d = beat_k + 8'd1;
          // Lambda'_i = Lambda_{i+1} for even i, zero for odd i.
          if (beat_k != 8'd0) begin
            wren_d = 1'b1;
            addr_d = {wr_bank_q, slot};
            data_d = beat_k[0] ? lambda_coef : 8'h00;
            if (beat_k[0] && (lambda_coef != 8'h00)) begin
              nz_d  = 1'b1;
              deg_d = slot;
            end
          end
          if (lambda_last) begin
            ptr_d   = beat_k;
            state_d = (beat_k >= MaxDeg) ? StDone : StFlush;
          end else if (beat_k == MaxDeg) begin
            ovf_d   = 1'b1;
            state_d = StDrain;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StDrain: begin
        if (beat && lambda_last) begin
          state_d = StDone;
        end
      end
      StFlush: begin
        wren_d = 1'b1;
        addr_d = {wr_bank_q, ptr_q[6:0]};
        data_d = 8'h00;
        ptr_d  = ptr_q + 8'd1;
        if (ptr_q == LastSlot) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d            = 1'b1;
        dbank_d           = wr_bank_q;
        ddeg_d            = deg_q;
        dzero_d           = !nz_q;
        dovf_d            = ovf_q;
        busy_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      run_q     <= 1'b0;
      wr_bank_q <= 1'b0;
      busy_q    <= 2'b00;
      k_q       <= '0;
      ptr_q     <= '0;
      deg_q     <= '0;
      nz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      wren_q    <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      dbank_q   <= 1'b0;
      ddeg_q    <= '0;
      dzero_q   <= 1'b0;
      dovf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      wr_bank_q <= wr_bank_d;
      busy_q    <= busy_d;
      k_q       <= k_d;
      ptr_q     <= ptr_d;
      deg_q     <= deg_d;
      nz_q      <= nz_d;
      ovf_q     <= ovf_d;
      wren_q    <= wren_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      dbank_q   <= dbank_d;
      ddeg_q    <= ddeg_d;
      dzero_q   <= dzero_d;
      dovf_q    <= dovf_d;
    end
  end

  assign buf_wren       = wren_q;
  assign buf_data       = data_q;
  assign buf_wraddress  = addr_q;
  assign deriv_done     = done_q;
  assign deriv_bank     = dbank_q;
  assign deriv_degree   = ddeg_q;
  assign deriv_zero     = dzero_q;
  assign deriv_overflow = dovf_q;

endmodule

// File: tb/tb_rs_derivative_writer.sv
// Self-checking bench for rs_derivative_writer: directed and random frames compared against
// a slot-level model of the derivative, write timing and completion report.
module tb_rs_derivative_writer;

  localparam int MAX_DEG = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       lambda_valid;
  logic [7:0] lambda_coef;
  logic       lambda_last;
  logic       lambda_ready;
  logic [7:0] buf_data;
  logic [7:0] buf_wraddress;
  logic       buf_wren;
  logic       deriv_done;
  logic       deriv_bank;
  logic [6:0] deriv_degree;
  logic       deriv_zero;
  logic       deriv_overflow;
  logic       bank_release;
  logic       release_bank;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int acc_q[$];
  int wa_q[$];
  int wd_q[$];
  int wc_q[$];
  int db_q[$];
  int dd_q[$];
  int dz_q[$];
  int dov_q[$];
  int dc_q[$];

  logic [7:0] coef_a [64];
  logic [7:0] coef_b [64];
  int exp_bank;

  rs_derivative_writer #(.MAX_DEG(MAX_DEG)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .lambda_valid   (lambda_valid),
    .lambda_coef    (lambda_coef),
    .lambda_last    (lambda_last),
    .lambda_ready   (lambda_ready),
    .buf_data       (buf_data),
    .buf_wraddress  (buf_wraddress),
    .buf_wren       (buf_wren),
    .deriv_done     (deriv_done),
    .deriv_bank     (deriv_bank),
    .deriv_degree   (deriv_degree),
    .deriv_zero     (deriv_zero),
    .deriv_overflow (deriv_overflow),
    .bank_release   (bank_release),
    .release_bank   (release_bank)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: beats seen at negedge are accepted on the next rising edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (lambda_valid && lambda_ready) acc_q.push_back(cyc);
      if (buf_wren) begin
        wa_q.push_back(int'(buf_wraddress));
        wd_q.push_back(int'(buf_data));
        wc_q.push_back(cyc);
      end
      if (deriv_done) begin
        db_q.push_back(int'(deriv_bank));
        dd_q.push_back(int'(deriv_degree));
        dz_q.push_back(int'(deriv_zero));
        dov_q.push_back(int'(deriv_overflow));
        dc_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_queues();
    acc_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete();
    db_q.delete(); dd_q.delete(); dz_q.delete(); dov_q.delete(); dc_q.delete();
  endtask

  task automatic drive_beat(input logic [7:0] c, input logic l);
    int waited;
    waited = 0;
    lambda_valid = 1'b1;
    lambda_coef  = c;
    lambda_last  = l;
    @(negedge clock);
    while (!lambda_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("ready_wait", (waited < 200), 1);
    if (lambda_ready) @(posedge clock);
    #1;
    lambda_valid = 1'b0;
    lambda_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      drive_beat(coef_a[k], (k == n - 1));
      if (gap) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic rel_bank(input int b);
    bank_release = 1'b1;
    release_bank = b[0];
    @(posedge clock);
    #1;
    bank_release = 1'b0;
  endtask

  // Model: slot i holds coef[i+1] for even i when that beat is within the first MAX_DEG+1.
  task automatic check_frame(input int bank, input int n);
    int used, waited, deg, zero, lastw;
    logic [7:0] d [MAX_DEG];
    waited = 0;
    lastw  = 0;
    while (dc_q.size() == 0 && waited < 400) begin
      @(posedge clock);
      #1;
      waited++;
    end
    check("done_seen", (dc_q.size() > 0), 1);
    if (dc_q.size() == 0) begin
      clear_queues();
      return;
    end
    used = (n > MAX_DEG + 1) ? MAX_DEG + 1 : n;
    deg  = 0;
    zero = 1;
    for (int i = 0; i < MAX_DEG; i++) begin
      d[i] = ((i % 2 == 0) && (i + 1 < used)) ? coef_a[i + 1] : 8'h00;
      if (d[i] != 8'h00) begin
        deg  = i;
        zero = 0;
      end
    end
    check("beat_count", acc_q.size(), n);
    check("write_count", wc_q.size(), MAX_DEG);
    if (acc_q.size() == n && wc_q.size() == MAX_DEG) begin
      for (int i = 0; i < MAX_DEG; i++) begin
        int ec;
        ec = (i + 1 < used) ? acc_q[i + 1] + 1 : acc_q[used - 1] + 2 + (i - (used - 1));
        check("wr_addr", wa_q[i], bank * 128 + i);
        check("wr_data", wd_q[i], int'(d[i]));
        check("wr_cycle", wc_q[i], ec);
        lastw = ec;
      end
      check("done_cycle", dc_q[0], (n > MAX_DEG + 1) ? acc_q[n - 1] + 2 : lastw + 1);
    end
    check("done_count", dc_q.size(), 1);
    check("done_bank", db_q[0], bank);
    check("done_degree", dd_q[0], deg);
    check("done_zero", dz_q[0], zero);
    check("done_overflow", dov_q[0], (n > MAX_DEG + 1) ? 1 : 0);
    clear_queues();
  endtask

  initial begin
    reset_n      = 1'b0;
    lambda_valid = 1'b0;
    lambda_coef  = 8'h00;
    lambda_last  = 1'b0;
    bank_release = 1'b0;
    release_bank = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_wren", buf_wren, 0);
    check("rst_data", buf_data, 0);
    check("rst_addr", buf_wraddress, 0);
    check("rst_done", deriv_done, 0);
    check("rst_bank", deriv_bank, 0);
    check("rst_degree", deriv_degree, 0);
    check("rst_zero", deriv_zero, 0);
    check("rst_overflow", deriv_overflow, 0);
    check("rst_ready", lambda_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Frame A: {01,53,0A,C1} -> 00=53, 01=00, 02=C1, degree 2.
    coef_a[0] = 8'h01; coef_a[1] = 8'h53; coef_a[2] = 8'h0A; coef_a[3] = 8'hC1;
    send_frame(4, 1'b0);
    check_frame(0, 4);
    rel_bank(1);  // bank 1 is not busy: must be ignored

    // Frame B: random, lands in bank 1.
    for (int k = 0; k < 10; k++) begin
      coef_a[k] = 8'($urandom);
      coef_b[k] = coef_a[k];
    end
    send_frame(10, 1'b0);
    check_frame(1, 10);

    // Both banks busy: a third frame must stall until bank 0 is released.
    lambda_valid = 1'b1;
    lambda_coef  = 8'h11;
    repeat (3) begin
      @(negedge clock);
      check("ready_blocked", lambda_ready, 0);
    end
    @(posedge clock);
    #1;
    lambda_valid = 1'b0;
    bank_release = 1'b1;
    release_bank = 1'b0;
    @(negedge clock);
    check("ready_before_release", lambda_ready, 0);
    @(posedge clock);
    #1;
    bank_release = 1'b0;
    check("ready_after_release", lambda_ready, 1);
    check("no_blocked_beats", acc_q.size(), 0);
    for (int k = 0; k < 16; k++) coef_a[k] = 8'($urandom);
    send_frame(16, 1'b0);
    check_frame(0, 16);

    // Frame D: only even terms nonzero -> derivative is identically zero.
    rel_bank(1);
    coef_a[0] = 8'h01; coef_a[1] = 8'h00; coef_a[2] = 8'h5E;
    send_frame(3, 1'b0);
    check_frame(1, 3);

    // Frame E: 20 beats of FF -> truncated at MAX_DEG, degree 14, overflow.
    rel_bank(0);
    for (int k = 0; k < 20; k++) coef_a[k] = 8'hFF;
    send_frame(20, 1'b0);
    check_frame(0, 20);

    // Frame F: frame B replayed with valid toggling every other cycle.
    rel_bank(1);
    for (int k = 0; k < 10; k++) coef_a[k] = coef_b[k];
    send_frame(10, 1'b1);
    check_frame(1, 10);

    // Reset mid-frame at beat 2: outputs drop at once and no completion is reported.
    rel_bank(0);
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h77, 1'b0);
    drive_beat(8'h33, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_wren", buf_wren, 0);
    check("midrst_addr", buf_wraddress, 0);
    check("midrst_data", buf_data, 0);
    check("midrst_ready", lambda_ready, 0);
    repeat (2) @(posedge clock);
    #1;
    check("midrst_no_done", dc_q.size(), 0);
    clear_queues();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < 5; k++) coef_a[k] = 8'($urandom);
    send_frame(5, 1'b0);
    check_frame(0, 5);
    rel_bank(0);
    exp_bank = 1;

    // Random frames, including a single-beat frame and overflow-length frames.
    for (int f = 0; f < 8; f++) begin
      int n;
      bit gap;
      n   = (f == 0) ? 1 : int'($urandom_range(1, MAX_DEG + 3));
      gap = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        coef_a[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      send_frame(n, gap);
      check_frame(exp_bank, n);
      rel_bank(exp_bank);
      exp_bank = 1 - exp_bank;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_derivative_writer.md
# rs_derivative_writer

Upstream feeder for the 256x8 derivative RAM in the Reed-Solomon decoder. It accepts the error-locator polynomial Λ(x) coefficients from the Berlekamp-Massey stage as a valid/ready stream and computes the formal derivative Λ'(x) over GF(2^8). It writes the derivative coefficients into the RAM write port, zero-fills unused slots, and hands completed banks to the Forney stage. Two RAM banks (address bit 7) are ping-ponged, so BM can load codeword n+1 while Forney reads codeword n.

## Interface
- MAX_DEG, 16, maximum Λ degree (2t); legal range 2..128; Λ'(x) occupies addresses 0..MAX_DEG-1 of a bank
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- lambda_valid  in  1  coefficient beat valid
- lambda_coef  in  8  Λ_k; beats arrive in order k = 0,1,2,…
- lambda_last  in  1  marks the final beat (highest-degree coefficient)
- lambda_ready  out  1  beat accepted when valid & ready
- buf_data  out  8  RAM write data
- buf_wraddress  out  8  {bank, slot[6:0]}
- buf_wren  out  1  RAM write enable
- deriv_done  out  1  one-cycle pulse: bank complete
- deriv_bank  out  1  bank just completed, valid with deriv_done
- deriv_degree  out  7  highest slot holding a nonzero coefficient, valid with deriv_done
- deriv_zero  out  1  Λ'(x) ≡ 0, valid with deriv_done
- deriv_overflow  out  1  frame was truncated at MAX_DEG, valid with deriv_done
- bank_release  in  1  one-cycle pulse from Forney: bank is free again
- release_bank  in  1  bank being released

## Operation
- Arithmetic: in GF(2^m), Λ'_i = Λ_{i+1} for even i and 0 for odd i.
- Writes per accepted beat k:
  - k=0: no write.
  - k odd: write Λ_k to slot k-1.
  - k even, k>0: write 0x00 to slot k-1.
- State machine: IDLE → LOAD → FLUSH → DONE → IDLE.
- IDLE / LOAD:
  - lambda_ready = !busy[wr_bank] and state ∈ {IDLE, LOAD}.
  - The first accepted beat moves IDLE → LOAD and clears the beat counter k, the degree tracker and the zero flag.
- Frame end in LOAD:
  - A beat with lambda_last goes to FLUSH.
  - Beat k = MAX_DEG without lambda_last also ends the frame: set deriv_overflow and ignore further beats until lambda_last is seen. lambda_ready stays high and discards them.
- FLUSH:
  - Writes 0x00 to slots (last written slot + 1) .. MAX_DEG-1, one per cycle.
  - A single-beat frame (k=0 last) flushes all slots 0..MAX_DEG-1.
  - When nothing remains to flush, go straight to DONE.
- DONE, one cycle:
  - Pulse deriv_done with deriv_bank = wr_bank.
  - Set busy[wr_bank], toggle wr_bank, return to IDLE.
- deriv_degree / deriv_zero:
  - Track the max slot written with nonzero data.
  - If none, deriv_degree = 0 and deriv_zero = 1.
- Bank release:
  - bank_release clears busy[release_bank].
  - Releasing a non-busy bank is ignored.
  - A release and a DONE on the other bank in the same cycle both take effect.
  - A release and a DONE setting the same bank cannot occur legally; if they do, set wins.
- Reset (async, any state):
  - state = IDLE, wr_bank = 0, busy = 00.
  - All outputs 0.
  - A partially written bank is abandoned without deriv_done; its stale contents are overwritten by the next frame.

## Timing
- Write latency: the beat accepted on edge n drives buf_wren / buf_data / buf_wraddress during cycle n+1 (registered outputs).
- FLUSH writes follow back-to-back, starting the cycle after the last beat's write.
- deriv_done asserts the cycle after the final RAM write, so the RAM contents are stable when Forney reacts.
- Throughput: frame of L beats = L + (flush count) + 1 cycles, i.e. MAX_DEG + 2 cycles when lambda_valid is continuous.
- lambda_ready depends only on registered state (no combinational path from lambda_valid).
- A release takes effect on lambda_ready one cycle after the bank_release edge.

## Test plan
- Λ = {01,53,0A,C1} (last on C1), MAX_DEG=16, bank 0 free:
  - Writes addr 00=53, 01=00, 02=C1, then 03..0F=00.
  - deriv_done with bank 0, degree 2, zero 0, overflow 0.
  - The next frame writes at 0x80..0x8F.
- Two back-to-back frames with no bank_release:
  - The third frame sees lambda_ready held 0.
  - Pulse bank_release with release_bank=0 → ready rises the next cycle and the frame writes at 0x00.
- Λ = {01,00,5E} (only even terms nonzero):
  - Writes 00=00, 01=00, then flush to 0F.
  - deriv_zero=1, deriv_degree=0.
- 20 beats, all 0xFF, no last until beat 19:
  - Only slots 0..15 written (odd slots 0x00, even slots 0xFF).
  - Beats 17..19 discarded; deriv_overflow=1, deriv_degree=14.
- reset_n pulled low mid-LOAD at beat 2:
  - Outputs 0 immediately, no deriv_done.
  - After release, the next frame writes at bank 0.
- lambda_valid toggling every other cycle:
  - Writes are spaced to match the accepted beats.
  - Contents are identical to the continuous case.
